// File: rtl/lif_neuron_multichan.sv
// Multi-channel leaky integrate-and-fire neuron with a time-multiplexed MAC, rest-seeking leak and refractory period.
// Optional adaptive threshold: define ADAPTIVE_THRESH_EN.
module lif_neuron_multichan #(
  parameter int unsigned N_CH      = 4,
  parameter int unsigned IN_BITS   = 6,
  parameter int unsigned W_BITS    = 4,
  parameter int unsigned V_BITS    = 10,
  parameter int unsigned REFR_BITS = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      params_ready,
  input  logic                      input_enable,
  input  logic [N_CH*IN_BITS-1:0]   chan_in,
  input  logic [N_CH*W_BITS-1:0]    weights,
  input  logic [V_BITS-1:0]         leak_rate,
  input  logic [3:0]                leak_cycles,
  input  logic [V_BITS-1:0]         threshold,
  input  logic [REFR_BITS-1:0]      refr_period,
  output logic                      spike_out,
  output logic [V_BITS-1:0]         v_mem_out,
  output logic                      busy,
  output logic                      overrun
);
  localparam int unsigned CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned PROD_W = IN_BITS + W_BITS + 1;
  localparam int unsigned ACC_W  = V_BITS + IN_BITS + W_BITS + $clog2(N_CH) + 1;
  localparam logic signed [ACC_W-1:0] V_MAX_S = ACC_W'(2**V_BITS - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, UPDATE, REFRAC} state_t;

  state_t                   state, state_nxt;
  logic [N_CH*IN_BITS-1:0]  chan_q;
  logic [N_CH*W_BITS-1:0]   w_q;
  logic signed [ACC_W-1:0]  acc, acc_nxt;
  logic [CH_W-1:0]          ch_idx, ch_idx_nxt;
  logic [3:0]               leak_cnt, leak_cnt_nxt;
  logic [REFR_BITS-1:0]     refr_cnt, refr_cnt_nxt;
  logic [V_BITS-1:0]        v_mem, v_mem_nxt;
  logic                     spike_nxt, overrun_nxt, latch_c;

  logic [IN_BITS-1:0]       chan_arr [N_CH];
  logic signed [W_BITS-1:0] w_arr    [N_CH];
  logic signed [PROD_W-1:0] chan_ext, w_ext, prod;
  logic signed [ACC_W-1:0]  rest_s, leak_s, leaked;
  logic [V_BITS-1:0]        clamped, thr_eff;
  logic                     do_leak_c, fire_c;

`ifdef ADAPTIVE_THRESH_EN
  logic [V_BITS-1:0] thr_off, thr_off_nxt;
  logic [V_BITS:0]   thr_sum, inc_sum;
`endif

  // Channel/weight unpack and the single shared multiplier
  always_comb begin
    for (int i = 0; i < int'(N_CH); i++) begin
      chan_arr[i] = chan_q[i*IN_BITS +: IN_BITS];
      w_arr[i]    = w_q[i*W_BITS +: W_BITS];
    end
    chan_ext = PROD_W'({1'b0, chan_arr[ch_idx]});
    w_ext    = PROD_W'(w_arr[ch_idx]);
    prod     = chan_ext * w_ext;
  end

  // Effective threshold
`ifdef ADAPTIVE_THRESH_EN
  always_comb begin
    thr_sum = {1'b0, threshold} + {1'b0, thr_off};
    inc_sum = {1'b0, thr_off} + {1'b0, threshold >> 3};
    thr_eff = thr_sum[V_BITS] ? '1 : thr_sum[V_BITS-1:0];
  end
`else
  assign thr_eff = threshold;
`endif

  // Leak toward rest without overshoot, then clamp to the membrane range
  always_comb begin
    rest_s    = ACC_W'(threshold >> 1);
    leak_s    = ACC_W'(leak_rate);
    do_leak_c = (leak_cnt == leak_cycles);
    leaked    = acc;
    if (do_leak_c) begin
      if (acc < rest_s) begin
        leaked = acc + leak_s;
        if (leaked > rest_s) leaked = rest_s;
      end else if (acc > rest_s) begin
        leaked = acc - leak_s;
        if (leaked < rest_s) leaked = rest_s;
      end
    end
    if (leaked[ACC_W-1])        clamped = '0;
    else if (leaked > V_MAX_S)  clamped = '1;
    else                        clamped = V_BITS'(leaked);
    fire_c = (clamped >= thr_eff);
  end

  always_comb begin
    state_nxt    = state;
    acc_nxt      = acc;
    ch_idx_nxt   = ch_idx;
    leak_cnt_nxt = leak_cnt;
    refr_cnt_nxt = refr_cnt;
    v_mem_nxt    = v_mem;
    spike_nxt    = 1'b0;
    overrun_nxt  = overrun;
    latch_c      = 1'b0;
`ifdef ADAPTIVE_THRESH_EN
    thr_off_nxt  = thr_off;
`endif
    if (enable) begin
      case (state)
        IDLE: begin
          if (input_enable && params_ready) begin
            latch_c    = 1'b1;
            acc_nxt    = ACC_W'(v_mem);
            ch_idx_nxt = '0;
            state_nxt  = ACCUM;
          end
        end
        ACCUM: begin
          acc_nxt = acc + ACC_W'(prod);
          if (input_enable) overrun_nxt = 1'b1;
          if (ch_idx == CH_W'(N_CH - 1)) state_nxt = UPDATE;
          else                           ch_idx_nxt = ch_idx + CH_W'(1);
        end
        UPDATE: begin
          if (input_enable) overrun_nxt = 1'b1;
          leak_cnt_nxt = do_leak_c ? 4'd0 : leak_cnt + 4'd1;
          if (fire_c) begin
            spike_nxt = 1'b1;
            v_mem_nxt = '0;
            if (refr_period != '0) begin
              refr_cnt_nxt = refr_period;
              state_nxt    = REFRAC;
            end else begin
              state_nxt    = IDLE;
            end
`ifdef ADAPTIVE_THRESH_EN
            thr_off_nxt = inc_sum[V_BITS] ? '1 : inc_sum[V_BITS-1:0];
`endif
          end else begin
            v_mem_nxt = clamped;
            state_nxt = IDLE;
`ifdef ADAPTIVE_THRESH_EN
            if (thr_off != '0) thr_off_nxt = thr_off - V_BITS'(1);
`endif
          end
        end
        REFRAC: begin
          refr_cnt_nxt = refr_cnt - REFR_BITS'(1);
          if (refr_cnt <= REFR_BITS'(1)) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chan_q    <= '0;
      w_q       <= '0;
      acc       <= '0;
      ch_idx    <= '0;
      leak_cnt  <= '0;
      refr_cnt  <= '0;
      v_mem     <= '0;
      spike_out <= 1'b0;
      overrun   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      if (latch_c) begin
        chan_q <= chan_in;
        w_q    <= weights;
      end
      acc       <= acc_nxt;
      ch_idx    <= ch_idx_nxt;
      leak_cnt  <= leak_cnt_nxt;
      refr_cnt  <= refr_cnt_nxt;
      v_mem     <= v_mem_nxt;
      spike_out <= spike_nxt;
      overrun   <= overrun_nxt;
      busy      <= (state_nxt != IDLE);
    end
  end

`ifdef ADAPTIVE_THRESH_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) thr_off <= '0;
    else       thr_off <= thr_off_nxt;
  end
`endif

  assign v_mem_out = v_mem;

endmodule
